weight_receiver: RTL and testbench
==================================

# weight_receiver

Receiving end of the pretrained-weight upload stream. Captures row-wise weight writes and per-layer bias vectors into per-layer storage banks. Tracks which rows have been loaded and declares the network ready only when every row of every layer has arrived. Sits between the weight-upload sequencer and the neuron datapath, which reads weight rows through a registered read port.

## Interface

- `layers`, default 2: number of stored layers.
- `datawidth`, default 11: weight word width; each bias is 2*datawidth wide.
- `rows[0:layers-1]`, default '{30,10}: neurons per layer.
- `cols[0:layers-1]`, default '{64,30}: inputs per neuron.
- `max_rows`, default 30 / `max_cols`, default 64: bus sizing.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_overall_n` in 1: reset, asynchronous, active-low.
- `clr_vals` in 1: synchronous clear of load state (same effect as reset except bank contents are kept).
- `train` in 1: write window; when 1, the row on the bus is written every cycle.
- `layer_select` in $clog2(layers): target layer.
- `row_select` in $clog2(max_rows): target row.
- `weight_update` in max_cols*datawidth, signed: row data; low cols[L]*datawidth bits are used.
- `bias_updates` in max_rows*2*datawidth, signed: full bias vector of the selected layer.
- `upload_done` in 1: end-of-upload pulse from the sequencer.
- `rd_en` in 1, `rd_layer` in $clog2(layers), `rd_row` in $clog2(max_rows): read request.
- `rd_valid` out 1, `rd_weights` out max_cols*datawidth, `rd_bias` out 2*datawidth: read response.
- `weights_ready` out 1: all rows loaded and upload confirmed.
- `load_error` out 1: sticky flag for an invalid write or an incomplete upload.
- `rows_loaded` out $clog2(sum rows+1): count of distinct rows written.

## Operation

- States are IDLE, RECEIVE, CHECK and READY.
  - IDLE → RECEIVE when train=1.
  - READY → RECEIVE when train=1. This starts a new upload: clear the valid bitmaps, rows_loaded, weights_ready and load_error.
  - RECEIVE → CHECK when upload_done=1.
  - CHECK → READY if every valid bit is set and load_error=0; otherwise CHECK → IDLE.
- Write cycle (train=1, any state except CHECK):
  - If layer_select<layers and row_select<rows[layer_select], write the row into bank[layer_select][row_select].
  - Copy bias_updates into that layer's bias register.
  - Set valid[layer][row]. Increment rows_loaded only if the bit was previously 0, so rewriting a row is harmless.
  - Otherwise drop the write and set load_error.
- Upper unused columns are zero-filled on write. rd_weights bits above cols[L]*datawidth always read 0.
- upload_done arriving in the same cycle as a train=1 write: the write is committed first, and CHECK evaluates the bitmap including it.
- upload_done in IDLE with no prior train: set load_error and stay in IDLE.
- Reads are accepted only in READY. rd_en outside READY gives no rd_valid and does not change the outputs.
- Out-of-range read address: rd_valid=1, data 0, load_error unchanged.
- Reset values: rd_valid=0, rd_weights=0, rd_bias=0, weights_ready=0, load_error=0, rows_loaded=0, state=IDLE, valid bitmaps all 0. Bank contents are undefined after reset.

## Timing

- Write latency is 1 cycle; a row written at edge N is readable at edge N+1 in READY.
- Read latency is 1 cycle: rd_en at edge N gives rd_valid=1 with data during cycle N+1. rd_valid is a single-cycle pulse per rd_en.
- weights_ready rises the cycle after CHECK (CHECK lasts exactly 1 cycle). It stays high until reset, clr_vals or a new train.
- A clr_vals or reset assertion mid-upload aborts immediately and returns to IDLE; the sequencer must restart the upload.
- There is no backpressure: the receiver accepts one row per cycle at full rate.

## Structure

- Shared package `ann_pkg` holds the `rx_state_t` enum, the default rows/cols tables, and a `total_rows` constant function.
- Sub-module `weight_row_bank` is one single-write, single-registered-read row memory per layer, generated for each layer. The top level muxes the read output on a registered rd_layer.

## Test plan

- Full upload, 30 rows to layer 0 then 10 rows to layer 1, then upload_done → rows_loaded=40, weights_ready=1 two cycles after upload_done; a read of layer 1 row 9 returns the written row.
- Row 29 of layer 0 written twice, then upload completed → rows_loaded=40 (not 41), load_error=0.
- Upload omitting layer 1 row 5, then upload_done → CHECK → IDLE, load_error=1, weights_ready=0.
- Write to layer 1 row 12 (≥rows[1]=10) → write dropped, load_error=1; bank row contents unchanged.
- rst_overall_n pulsed low after 15 rows → all outputs at reset values; a fresh full upload then reaches READY.
- Read of layer 1 row 3 in READY → rd_valid exactly 1 cycle later, upper (64-30)*11 bits = 0, rd_bias = bias slot 3 of layer 1.

Source files
------------

// File: rtl/ann_pkg.sv
// rtl/ann_pkg.sv - shared types and layer geometry for the weight upload path
package ann_pkg;
  typedef enum logic [1:0] {IDLE, RECEIVE, CHECK, READY} rx_state_t;

  localparam int ann_layers = 2;
  localparam int ann_rows [0:ann_layers-1] = '{30, 10};
  localparam int ann_cols [0:ann_layers-1] = '{64, 30};

  function automatic int total_rows(input int r [0:ann_layers-1]);
    int s;
    s = 0;
    for (int i = 0; i < ann_layers; i++) s += r[i];
    return s;
  endfunction
endpackage

// File: rtl/weight_row_bank.sv
// rtl/weight_row_bank.sv - one layer's row memory, single write, registered read
module weight_row_bank #(
  parameter int depth = 30,
  parameter int width = 704,
  parameter int aw    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic             re,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata
);
  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/weight_receiver.sv
// rtl/weight_receiver.sv - captures uploaded weight rows and biases, tracks completeness
module weight_receiver
  import ann_pkg::*;
#(
  parameter int layers    = ann_layers,
  parameter int datawidth = 11,
  parameter int rows [0:layers-1] = ann_rows,
  parameter int cols [0:layers-1] = ann_cols,
  parameter int max_rows  = 30,
  parameter int max_cols  = 64
) (
  input  logic                                   clk,
  input  logic                                   rst_overall_n,
  input  logic                                   clr_vals,
  input  logic                                   train,
  input  logic [$clog2(layers)-1:0]              layer_select,
  input  logic [$clog2(max_rows)-1:0]            row_select,
  input  logic signed [max_cols*datawidth-1:0]   weight_update,
  input  logic signed [max_rows*2*datawidth-1:0] bias_updates,
  input  logic                                   upload_done,
  input  logic                                   rd_en,
  input  logic [$clog2(layers)-1:0]              rd_layer,
  input  logic [$clog2(max_rows)-1:0]            rd_row,
  output logic                                   rd_valid,
  output logic [max_cols*datawidth-1:0]          rd_weights,
  output logic [2*datawidth-1:0]                 rd_bias,
  output logic                                   weights_ready,
  output logic                                   load_error,
  output logic [$clog2(total_rows(rows)+1)-1:0]  rows_loaded
);
  localparam int lw = $clog2(layers);
  localparam int ww = max_cols * datawidth;
  localparam int bw = 2 * datawidth;
  localparam int cw = $clog2(total_rows(rows) + 1);

  rx_state_t           state;
  logic [max_rows-1:0] valid  [layers];
  logic [max_rows*bw-1:0] bias_q [layers];
  logic [ww-1:0]       bank_rd [layers];
  logic [lw-1:0]       rd_layer_q;
  logic                rd_zero_q;
  logic wr_in_range, rd_in_range, all_valid;
  logic wr_cycle, wr_ok, bad_wr, restart, new_row, rd_accept;

  always_comb begin
    wr_in_range = 1'b0;
    rd_in_range = 1'b0;
    all_valid   = 1'b1;
    for (int l = 0; l < layers; l++) begin
      if (layer_select == lw'(l) && int'(row_select) < rows[l]) wr_in_range = 1'b1;
      if (rd_layer == lw'(l) && int'(rd_row) < rows[l]) rd_in_range = 1'b1;
      if ((valid[l] | ~({max_rows{1'b1}} >> (max_rows - rows[l]))) != '1) all_valid = 1'b0;
    end
  end

  assign wr_cycle  = train && state != CHECK && !clr_vals;
  assign wr_ok     = wr_cycle && wr_in_range;
  assign bad_wr    = wr_cycle && !wr_in_range;
  assign restart   = train && state == READY && !clr_vals;
  assign new_row   = wr_ok && (restart || !valid[layer_select][row_select]);
  assign rd_accept = rd_en && state == READY;

  always_ff @(posedge clk or negedge rst_overall_n) begin
    if (!rst_overall_n) begin
      state         <= IDLE;
      for (int l = 0; l < layers; l++) valid[l] <= '0;
      rows_loaded   <= '0;
      weights_ready <= 1'b0;
      load_error    <= 1'b0;
      rd_valid      <= 1'b0;
      rd_bias       <= '0;
      rd_layer_q    <= '0;
      rd_zero_q     <= 1'b1;
    end else if (clr_vals) begin
      state         <= IDLE;
      for (int l = 0; l < layers; l++) valid[l] <= '0;
      rows_loaded   <= '0;
      weights_ready <= 1'b0;
      load_error    <= 1'b0;
      rd_valid      <= 1'b0;
      rd_bias       <= '0;
      rd_layer_q    <= '0;
      rd_zero_q     <= 1'b1;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_layer_q <= rd_layer;
        rd_zero_q  <= !rd_in_range;
        rd_bias    <= rd_in_range ? bias_q[rd_layer][rd_row*bw +: bw] : '0;
      end
      // A restart clears the bitmap first; the same cycle's write then lands on top.
      if (restart) for (int l = 0; l < layers; l++) valid[l] <= '0;
      if (wr_ok) valid[layer_select][row_select] <= 1'b1;
      rows_loaded <= (restart ? '0 : rows_loaded) + cw'(new_row);
      load_error  <= (load_error && !restart) || bad_wr
                     || (state == IDLE && upload_done && !train)
                     || (state == CHECK && !all_valid);
      case (state)
        IDLE:    if (train) state <= RECEIVE;
        RECEIVE: if (upload_done) state <= CHECK;
        CHECK: begin
          if (all_valid && !load_error) begin
            state         <= READY;
            weights_ready <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        READY: begin
          if (train) begin
            state         <= RECEIVE;
            weights_ready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < layers; l++)
      if (wr_ok && layer_select == lw'(l)) bias_q[l] <= bias_updates;
  end

  for (genvar g = 0; g < layers; g++) begin : g_bank
    localparam int aw = (rows[g] > 1) ? $clog2(rows[g]) : 1;
    logic [cols[g]*datawidth-1:0] rdata;

    // Only the used columns are stored, so upper bits read back as zero.
    weight_row_bank #(
      .depth(rows[g]),
      .width(cols[g] * datawidth),
      .aw   (aw)
    ) u_bank (
      .clk  (clk),
      .we   (wr_ok && layer_select == lw'(g)),
      .waddr(row_select[aw-1:0]),
      .wdata(weight_update[cols[g]*datawidth-1:0]),
      .re   (rd_accept && rd_in_range && rd_layer == lw'(g)),
      .raddr(rd_row[aw-1:0]),
      .rdata(rdata)
    );

    assign bank_rd[g] = ww'(rdata);
  end

  assign rd_weights = rd_zero_q ? '0 : bank_rd[rd_layer_q];
endmodule

// File: tb/tb_weight_receiver.sv
// tb/tb_weight_receiver.sv - directed checks of upload, completeness tracking and reads
module tb_weight_receiver;
  localparam int dw = 11;
  localparam int ww = 64 * dw;
  localparam int bw = 2 * dw;

  logic clk = 1'b0;
  logic rst_overall_n, clr_vals, train, upload_done, rd_en;
  logic [0:0] layer_select, rd_layer;
  logic [4:0] row_select, rd_row;
  logic [ww-1:0] weight_update;
  logic [30*bw-1:0] bias_updates;
  logic rd_valid, weights_ready, load_error;
  logic [ww-1:0] rd_weights;
  logic [bw-1:0] rd_bias;
  logic [5:0] rows_loaded;

  int tb_rows [2] = '{30, 10};
  int tb_cols [2] = '{64, 30};
  int seed;
  int n_checks = 0;
  int n_pass = 0;
  logic [ww-1:0] last_exp_w;

  typedef struct {int l; int r; bit in_rng;} rd_vec_t;
  rd_vec_t rv [8];

  weight_receiver dut (
    .clk(clk), .rst_overall_n(rst_overall_n), .clr_vals(clr_vals), .train(train),
    .layer_select(layer_select), .row_select(row_select), .weight_update(weight_update),
    .bias_updates(bias_updates), .upload_done(upload_done), .rd_en(rd_en),
    .rd_layer(rd_layer), .rd_row(rd_row), .rd_valid(rd_valid), .rd_weights(rd_weights),
    .rd_bias(rd_bias), .weights_ready(weights_ready), .load_error(load_error),
    .rows_loaded(rows_loaded)
  );

  always #5 clk = ~clk;

  function automatic logic [ww-1:0] row_pattern(int l, int r);
    logic [ww-1:0] v;
    for (int c = 0; c < 64; c++) v[c*dw +: dw] = dw'(seed*131 + l*977 + r*37 + c*5 + 3);
    return v;
  endfunction

  function automatic logic [ww-1:0] exp_row(int l, int r);
    logic [ww-1:0] v;
    v = row_pattern(l, r);
    for (int c = tb_cols[l]; c < 64; c++) v[c*dw +: dw] = '0;
    return v;
  endfunction

  function automatic logic [bw-1:0] bias_slot(int l, int s);
    return bw'(seed*4099 + l*1000 + s*7 + 1);
  endfunction

  function automatic logic [30*bw-1:0] bias_vec(int l);
    logic [30*bw-1:0] v;
    for (int s = 0; s < 30; s++) v[s*bw +: bw] = bias_slot(l, s);
    return v;
  endfunction

  task automatic check(string name, logic [ww-1:0] act, logic [ww-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(int l, int r, bit done);
    train         = 1'b1;
    layer_select  = 1'(l);
    row_select    = 5'(r);
    weight_update = row_pattern(l, r);
    bias_updates  = bias_vec(l);
    upload_done   = done;
    tick();
    train       = 1'b0;
    upload_done = 1'b0;
  endtask

  task automatic upload(int skip_l, int skip_r, bit dup, bit done_with_last);
    for (int l = 0; l < 2; l++)
      for (int r = 0; r < tb_rows[l]; r++) begin
        if (!(l == skip_l && r == skip_r))
          write_row(l, r, done_with_last && l == 1 && r == 9);
        if (dup && l == 0 && r == 29) write_row(0, 29, 1'b0);
      end
  endtask

  task automatic pulse_done();
    upload_done = 1'b1;
    tick();
    upload_done = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_vals = 1'b1;
    tick();
    clr_vals = 1'b0;
  endtask

  task automatic do_read(int l, int r, bit in_rng);
    string tag;
    tag      = $sformatf("rd l%0d r%0d", l, r);
    rd_en    = 1'b1;
    rd_layer = 1'(l);
    rd_row   = 5'(r);
    tick();
    rd_en = 1'b0;
    check({tag, " valid"}, ww'(rd_valid), ww'(1));
    check({tag, " weights"}, rd_weights, in_rng ? exp_row(l, r) : '0);
    check({tag, " bias"}, ww'(rd_bias), in_rng ? ww'(bias_slot(l, r)) : '0);
    tick();
    check({tag, " valid pulse"}, ww'(rd_valid), ww'(0));
  endtask

  initial begin
    rst_overall_n = 1'b0; clr_vals = 1'b0; train = 1'b0; upload_done = 1'b0; rd_en = 1'b0;
    layer_select = '0; row_select = '0; rd_layer = '0; rd_row = '0;
    weight_update = '0; bias_updates = '0; seed = 1;
    rv[0] = '{1, 9, 1'b1};  rv[1] = '{1, 3, 1'b1};  rv[2] = '{0, 0, 1'b1};
    rv[3] = '{1, 12, 1'b0}; rv[4] = '{0, 30, 1'b0}; rv[5] = '{1, 10, 1'b0};
    rv[6] = '{1, 0, 1'b1};  rv[7] = '{0, 29, 1'b1};

    tick(); tick();
    rst_overall_n = 1'b1;
    tick();
    check("reset rd_valid", ww'(rd_valid), ww'(0));
    check("reset rd_weights", rd_weights, '0);
    check("reset rd_bias", ww'(rd_bias), '0);
    check("reset weights_ready", ww'(weights_ready), ww'(0));
    check("reset load_error", ww'(load_error), ww'(0));
    check("reset rows_loaded", ww'(rows_loaded), ww'(0));

    // upload_done with no preceding train
    pulse_done();
    check("idle done load_error", ww'(load_error), ww'(1));
    check("idle done weights_ready", ww'(weights_ready), ww'(0));
    pulse_clr();
    check("clr load_error", ww'(load_error), ww'(0));

    // full upload with a duplicated row 29 of layer 0
    upload(-1, -1, 1'b1, 1'b0);
    check("dup rows_loaded", ww'(rows_loaded), ww'(40));
    pulse_done();
    check("check-cycle weights_ready", ww'(weights_ready), ww'(0));
    tick();
    check("full weights_ready", ww'(weights_ready), ww'(1));
    check("full load_error", ww'(load_error), ww'(0));
    check("full rows_loaded", ww'(rows_loaded), ww'(40));

    for (int i = 0; i < 8; i++) do_read(rv[i].l, rv[i].r, rv[i].in_rng);
    last_exp_w = exp_row(0, 29);

    // new upload starting with an invalid row
    write_row(1, 12, 1'b0);
    check("bad row load_error", ww'(load_error), ww'(1));
    check("bad row rows_loaded", ww'(rows_loaded), ww'(0));
    check("restart weights_ready", ww'(weights_ready), ww'(0));
    rd_en = 1'b1; rd_layer = 1'b1; rd_row = 5'd3;
    tick();
    rd_en = 1'b0;
    check("read outside READY valid", ww'(rd_valid), ww'(0));
    check("read outside READY data", rd_weights, last_exp_w);
    pulse_done();
    tick();
    check("bad upload weights_ready", ww'(weights_ready), ww'(0));
    check("bad upload load_error", ww'(load_error), ww'(1));

    // incomplete upload: layer 1 row 5 missing
    pulse_clr();
    check("clr rows_loaded", ww'(rows_loaded), ww'(0));
    check("clr rd_weights", rd_weights, '0);
    seed = 2;
    upload(1, 5, 1'b0, 1'b0);
    check("missing rows_loaded", ww'(rows_loaded), ww'(39));
    pulse_done();
    tick();
    check("missing weights_ready", ww'(weights_ready), ww'(0));
    check("missing load_error", ww'(load_error), ww'(1));

    // asynchronous reset mid-upload, then a full upload ending with done on the last write
    pulse_clr();
    seed = 3;
    for (int r = 0; r < 15; r++) write_row(0, r, 1'b0);
    check("partial rows_loaded", ww'(rows_loaded), ww'(15));
    rst_overall_n = 1'b0;
    #2;
    check("async reset rows_loaded", ww'(rows_loaded), ww'(0));
    check("async reset load_error", ww'(load_error), ww'(0));
    check("async reset weights_ready", ww'(weights_ready), ww'(0));
    check("async reset rd_weights", rd_weights, '0);
    tick();
    rst_overall_n = 1'b1;
    tick();
    upload(-1, -1, 1'b0, 1'b1);
    check("done-with-write check cycle", ww'(weights_ready), ww'(0));
    tick();
    check("after reset weights_ready", ww'(weights_ready), ww'(1));
    check("after reset rows_loaded", ww'(rows_loaded), ww'(40));
    check("after reset load_error", ww'(load_error), ww'(0));
    do_read(0, 5, 1'b1);
    do_read(1, 9, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
